// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter states and line-level constants
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts 0..P-1 per bit period and pulses bit_done on the last cycle
module uart_bit_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       run,
    input  logic [5:0] prescale,
    output logic       bit_done
);
    logic [5:0] p_q, p_d, cnt_q, cnt_d;
    assign bit_done = run && (cnt_q == p_q - 6'd1);
    always_comb begin
        p_d   = p_q;
        cnt_d = cnt_q;
        if (load) begin
            p_d   = (prescale == 6'd0) ? 6'd1 : prescale;
            cnt_d = 6'd0;
        end else if (run) begin
            cnt_d = bit_done ? 6'd0 : cnt_q + 6'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            p_q   <= 6'd1;
            cnt_q <= 6'd0;
        end else begin
            p_q   <= p_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx_prescaled.sv
// uart_tx_prescaled: prescale-timed UART transmitter with a one-entry holding register
module uart_tx_prescaled
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            prescale,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] parallel_data,
    output logic                  ready,
    output logic                  serial_data_out,
    output logic                  busy
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    tx_state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, hold_q, hold_d;
    logic hold_full_q, hold_full_d, par_en_q, par_en_d, par_type_q, par_type_d;
    logic line_q, line_d, bit_done, start_frame;
    assign ready           = !hold_full_q;
    assign busy            = state_q != IDLE;
    assign serial_data_out = line_q;
    assign start_frame     = hold_full_q && (state_q == IDLE || (state_q == STOP && bit_done));
    uart_bit_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (start_frame),
        .run      (busy),
        .prescale (prescale),
        .bit_done (bit_done)
    );
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        par_en_d    = par_en_q;
        par_type_d  = par_type_q;
        if (data_valid && ready) begin
            hold_d      = parallel_data;
            hold_full_d = 1'b1;
        end
        if (start_frame) begin
            shift_d     = hold_q;
            par_en_d    = parity_enable;
            par_type_d  = parity_type;
            hold_full_d = 1'b0;
            idx_d       = '0;
            state_d     = START;
        end else if (bit_done) begin
            case (state_q)
                START:   state_d = DATA;
                DATA: begin
                    idx_d = (idx_q == IW'(DATA_WIDTH - 1)) ? '0 : idx_q + IW'(1);
                    state_d = (idx_q != IW'(DATA_WIDTH - 1)) ? DATA : par_en_q ? PARITY : STOP;
                end
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        // The line is computed from the next state so the output is a pure flop
        line_d = (state_d == START)  ? START_BIT :
                 (state_d == DATA)   ? shift_d[idx_d] :
                 (state_d == PARITY) ? (^shift_d ^ par_type_d) :
                 (state_d == STOP)   ? STOP_BIT : LINE_IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            par_en_q    <= 1'b0;
            par_type_q  <= PARITY_EVEN;
            line_q      <= LINE_IDLE;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            par_en_q    <= par_en_d;
            par_type_q  <= par_type_d;
            line_q      <= line_d;
        end
    end
endmodule
